// File: rtl/ssd_pkg.sv
// Shared constants, FSM encoding and word-packing helper for the
// seven-segment BCD feeder.
package ssd_pkg;

    localparam int DIGITS  = 4;
    localparam int SLOT_W  = 5;
    localparam int MAX_VAL = 9999;
    localparam logic [DIGITS*SLOT_W-1:0] RESET_WORD = 20'h84210;
    localparam logic DP_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    // Each 5-bit slot is {decimal point, BCD digit}, digit 0 in the low slot.
    function automatic logic [DIGITS*SLOT_W-1:0] pack_word(
        input logic [DIGITS-1:0]   dp_n,
        input logic [DIGITS*4-1:0] bcd
    );
        logic [DIGITS*SLOT_W-1:0] w;
        w = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w[i*SLOT_W +: SLOT_W] = {dp_n[i], bcd[i*4 +: 4]};
        end
        return w;
    endfunction

endpackage

// File: rtl/ssd_bcd_feeder_if.sv
// Request/result bundle between a host and the BCD feeder.
interface ssd_bcd_feeder_if #(parameter int BIN_W = 14);
    import ssd_pkg::*;

    logic                     start;
    logic [BIN_W-1:0]         bin;
    logic [DIGITS-1:0]        dp_n;
    logic                     busy;
    logic                     done;
    logic                     ovf;
    logic [DIGITS*SLOT_W-1:0] output_word;

    modport master (output start, bin, dp_n, input busy, done, ovf, output_word);
    modport slave  (input start, bin, dp_n, output busy, done, ovf, output_word);

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/ssd_bcd_feeder.sv
// Sequential binary-to-BCD converter that publishes a packed scan-driver word
// only once the full conversion is complete.
module ssd_bcd_feeder
    import ssd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    ssd_bcd_feeder_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = DIGITS * 4;

    state_t             state;
    logic [BIN_W-1:0]   bin_sr;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   step_cnt;
    logic [DIGITS-1:0]  dp_cap;
    logic               ovf_cap;
    logic               over_max;

    assign over_max = (bus.bin > BIN_W'(MAX_VAL));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_sr[g*4 +: 4]),
            .adjusted (bcd_adj[g*4 +: 4])
        );
    end

    // Clamping at capture keeps every digit in 0..9 without post-correction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bin_sr          <= '0;
            bcd_sr          <= '0;
            step_cnt        <= '0;
            dp_cap          <= {DIGITS{DP_OFF}};
            ovf_cap         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.ovf         <= 1'b0;
            bus.output_word <= RESET_WORD;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= over_max ? BIN_W'(MAX_VAL) : bus.bin;
                        dp_cap   <= bus.dp_n;
                        ovf_cap  <= over_max;
                        bcd_sr   <= '0;
                        step_cnt <= '0;
                        bus.busy <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    step_cnt         <= step_cnt + 1'b1;
                    if (step_cnt == CNT_W'(BIN_W - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.output_word <= pack_word(dp_cap, bcd_sr);
                    bus.ovf         <= ovf_cap;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_bcd_feeder.sv
// Randomized self-checking bench for ssd_bcd_feeder against a decimal-arithmetic model.
module tb_ssd_bcd_feeder;
    import ssd_pkg::*;

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;
    localparam int GAP   = BIN_W + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [19:0] exp_word;
    logic        exp_ovf;

    ssd_bcd_feeder_if #(.BIN_W(BIN_W)) bus ();

    ssd_bcd_feeder #(.BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: clamp, split into decimal digits, interleave decimal points.
    function automatic logic [19:0] model_word(input int v, input logic [3:0] dp);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {dp[3], 4'(c / 1000), dp[2], 4'((c / 100) % 10),
                dp[1], 4'((c / 10) % 10), dp[0], 4'(c % 10)};
    endfunction

    // Drives one START pulse, scrambles inputs after capture, waits for DONE.
    task automatic do_conv(input int v, input logic [3:0] dp,
                           output int lat, output logic [19:0] word,
                           output logic of, output bit held, output bit busy_ok);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bin   = BIN_W'(v);
        bus.dp_n  = dp;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bin   = BIN_W'($urandom);
        bus.dp_n  = 4'($urandom);
        busy_ok   = (bus.busy === 1'b1);
        held      = 1'b1;
        lat       = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.output_word !== exp_word || bus.ovf !== exp_ovf) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        word = bus.output_word;
        of   = bus.ovf;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
        total++; if (bus.output_word !== 20'h84210) begin bad++; $display("[TB] FAIL reset_word: got %h want 84210", bus.output_word); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_word = 20'h84210;
        exp_ovf  = 1'b0;
    endtask

    task automatic test_known_vectors();
        int          vals [5] = '{1234, 0, 9999, 12000, 5};
        logic [3:0]  dps  [5] = '{4'b1101, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [19:0] want [5] = '{20'h8C874, 20'h84210, 20'hCE739, 20'hCE739, 20'h84215};
        logic        wovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat; logic [19:0] word; logic of; bit held, busy_ok;
        for (int i = 0; i < 5; i++) begin
            do_conv(vals[i], dps[i], lat, word, of, held, busy_ok);
            total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL known_latency[%0d]: got %0d want %0d", i, lat, LAT); end
            total++; if (word !== want[i]) begin bad++; $display("[TB] FAIL known_word[%0d]: got %h want %h", i, word, want[i]); end
            total++; if (of !== wovf[i]) begin bad++; $display("[TB] FAIL known_ovf[%0d]: got %b want %b", i, of, wovf[i]); end
            total++; if (!held) begin bad++; $display("[TB] FAIL known_held[%0d]: got changed want held %h", i, exp_word); end
            total++; if (!busy_ok) begin bad++; $display("[TB] FAIL known_busy[%0d]: got wrong busy want 1 then 0", i); end
            exp_word = want[i];
            exp_ovf  = wovf[i];
        end
    endtask

    task automatic test_random();
        int lat; logic [19:0] word, want; logic of; bit held, busy_ok;
        for (int i = 0; i < 20; i++) begin
            int v;
            logic [3:0] dp;
            v    = (i % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            dp   = 4'($urandom);
            want = model_word(v, dp);
            do_conv(v, dp, lat, word, of, held, busy_ok);
            total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL rand_latency v=%0d: got %0d want %0d", v, lat, LAT); end
            total++; if (word !== want) begin bad++; $display("[TB] FAIL rand_word v=%0d: got %h want %h", v, word, want); end
            total++; if (of !== (v > 9999)) begin bad++; $display("[TB] FAIL rand_ovf v=%0d: got %b want %b", v, of, (v > 9999)); end
            total++; if (!held) begin bad++; $display("[TB] FAIL rand_held v=%0d: got changed want held %h", v, exp_word); end
            exp_word = want;
            exp_ovf  = (v > 9999);
        end
    endtask

    task automatic test_ignore_restart();
        int b1, b2, dones;
        logic [19:0] first_word, want;
        b1 = $urandom_range(0, 4999);
        b2 = $urandom_range(5000, 9999);
        want = model_word(b1, 4'hF);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.bin = BIN_W'(b1); bus.dp_n = 4'hF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        first_word = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) begin bus.start = 1'b1; bus.bin = BIN_W'(b2); end
            if (cyc == 5) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                if (dones == 0) first_word = bus.output_word;
                dones++;
            end
        end
        total++; if (dones != 1) begin bad++; $display("[TB] FAIL restart_done_count: got %0d want 1", dones); end
        total++; if (first_word !== want) begin bad++; $display("[TB] FAIL restart_word: got %h want %h", first_word, want); end
        exp_word = want;
        exp_ovf  = 1'b0;
    endtask

    task automatic test_mid_reset();
        int lat, dones, v; logic [19:0] word, want; logic of; bit held, busy_ok;
        do_conv(4321, 4'b0110, lat, word, of, held, busy_ok);
        want = model_word(4321, 4'b0110);
        total++; if (word !== want) begin bad++; $display("[TB] FAIL prereset_word: got %h want %h", word, want); end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.bin = BIN_W'(8765); bus.dp_n = 4'h0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b want 0", bus.busy); end
        total++; if (bus.output_word !== 20'h84210) begin bad++; $display("[TB] FAIL midreset_word: got %h want 84210", bus.output_word); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("[TB] FAIL midreset_ovf: got %b want 0", bus.ovf); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL midreset_no_done: got %0d want 0", dones); end
        exp_word = 20'h84210;
        exp_ovf  = 1'b0;
        v = $urandom_range(1, 9999);
        want = model_word(v, 4'b1010);
        do_conv(v, 4'b1010, lat, word, of, held, busy_ok);
        total++; if (lat !== LAT) begin bad++; $display("[TB] FAIL postreset_latency: got %0d want %0d", lat, LAT); end
        total++; if (word !== want) begin bad++; $display("[TB] FAIL postreset_word: got %h want %h", word, want); end
        exp_word = want;
    endtask

    task automatic test_back_to_back();
        int vals[$];
        int idx, cyc, last_done;
        logic [19:0] want;
        vals = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999};
        for (int i = 0; i < 15; i++) vals.push_back(int'($urandom_range(0, 9999)));
        @(posedge clk); #1;
        bus.start = 1'b1; bus.bin = BIN_W'(vals[0]); bus.dp_n = 4'hF;
        idx = 0; cyc = 0; last_done = 0;
        while (idx < vals.size() && cyc < vals.size() * GAP + 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) begin
                want = model_word(vals[idx], 4'hF);
                total++; if (bus.output_word !== want) begin bad++; $display("[TB] FAIL b2b_word v=%0d: got %h want %h", vals[idx], bus.output_word, want); end
                if (idx > 0) begin
                    total++; if (cyc - last_done != GAP) begin bad++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", cyc - last_done, GAP); end
                end
                last_done = cyc;
                idx++;
                if (idx < vals.size()) bus.bin = BIN_W'(vals[idx]);
            end
        end
        bus.start = 1'b0;
        total++; if (idx != vals.size()) begin bad++; $display("[TB] FAIL b2b_timeout: got %0d results want %0d", idx, vals.size()); end
        repeat (GAP + 2) @(posedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        bus.dp_n  = 4'hF;
        exp_word  = 20'h84210;
        exp_ovf   = 1'b0;
        test_reset();
        test_known_vectors();
        test_random();
        test_ignore_restart();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_bcd_feeder.md
SSD_BCD_FEEDER -- requirements
Module: ssd_bcd_feeder

Interface
REQ-001 Parameter BIN_W, default 14, binary input width; legal range 14..16.
REQ-002 CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 START  in  1  request to convert; sampled only in IDLE.
REQ-005 BIN  in  BIN_W  unsigned binary value to display.
REQ-006 DP_N  in  4  decimal-point enables, one per digit, active-low (0 = lit); bit i pairs with digit i.
REQ-007 BUSY  out  1  conversion in progress.
REQ-008 DONE  out  1  one-cycle pulse when OUTPUT is updated.
REQ-009 OVF  out  1  last converted value exceeded 9999; valid from DONE until the next DONE.
REQ-010 OUTPUT  out  20  packed scan-driver word {DP_N[3],D3,DP_N[2],D2,DP_N[1],D1,DP_N[0],D0}; Dn is a 4-bit BCD digit, D0 least significant.

Function
REQ-011 The FSM SHALL have states IDLE, CONVERT and FINISH.
REQ-012 In IDLE with START=1 at edge k, the block SHALL capture min(BIN,9999), DP_N and the overflow flag (BIN>9999), clear the BCD shift register, load the iteration counter with 0, set BUSY=1 and enter CONVERT.
REQ-013 In CONVERT, each edge SHALL perform one double-dabble step: add 3 to every BCD nibble >=5, then shift {BCD,binary} left by one.
REQ-014 After exactly BIN_W steps (edges k+1..k+BIN_W), the FSM SHALL enter FINISH.
REQ-015 At edge k+BIN_W+1 (FINISH), OUTPUT SHALL load the packed result, OVF SHALL load the captured flag, DONE SHALL be 1 for that single cycle, BUSY SHALL drop to 0, and the FSM SHALL return to IDLE.
REQ-016 Latency from the START-sampling edge to DONE SHALL be BIN_W+1 cycles (15 at default).
REQ-017 START while in CONVERT or FINISH SHALL be ignored; the earliest restart is the edge after DONE.
REQ-018 OUTPUT and OVF SHALL hold their previous values throughout CONVERT; no intermediate digit SHALL ever appear on OUTPUT.
REQ-019 BIN and DP_N changes after the capture edge SHALL NOT affect the conversion in progress.
REQ-020 Every BCD nibble on OUTPUT SHALL lie in 0..9; values >9999 SHALL display 9999.
REQ-021 START held high continuously SHALL produce back-to-back conversions every BIN_W+2 cycles.

Reset
REQ-022 RST=1 SHALL immediately, without waiting for CLK, force state IDLE, BUSY=0, DONE=0, OVF=0, and OUTPUT=20'h84210 (all digits 0, all decimal points off).
REQ-023 RST asserted mid-conversion SHALL abandon the conversion with no DONE pulse; OUTPUT SHALL show the reset value.
REQ-024 The first START sampled after RST deasserts SHALL be accepted normally.

Structure
REQ-025 Shared package ssd_pkg SHALL hold: digit count (4), slot width (5), max displayable value (9999), reset word 20'h84210, the dp-off constant (1'b1), and the FSM state encoding.
REQ-026 The per-nibble add-3 correction SHALL be a combinational sub-module bcd_digit_adjust, instantiated once per digit.
REQ-027 The iteration counter SHALL be ceil(log2(BIN_W+1)) bits wide.

Verification
REQ-028 BIN=1234, DP_N=4'b1101, START pulse -> DONE 15 cycles later, OUTPUT=20'h8C874, OVF=0.
REQ-029 BIN=0, DP_N=4'hF -> OUTPUT=20'h84210, OVF=0; BIN=9999, DP_N=4'hF -> OUTPUT=20'hCE739, OVF=0.
REQ-030 BIN=12000, DP_N=4'hF -> OUTPUT=20'hCE739, OVF=1; a following BIN=5 conversion -> OVF=0.
REQ-031 START re-pulsed with a new BIN during CONVERT -> ignored; exactly one DONE, carrying the original value.
REQ-032 RST pulsed at cycle 7 of a conversion -> no DONE, BUSY=0, OUTPUT=20'h84210 immediately.
REQ-033 START held high, BIN counted 0..9999 -> every DONE shows the correct BCD digits, DONE spacing is 16 cycles.
